led_matrix_scan_pwm: RTL and testbench
======================================

# led_matrix_scan_pwm

Parametrised row-scan driver for a bicolour (red/green) LED matrix, successor to the fixed 8x8 on/off scanner. Takes a per-pixel, per-colour intensity frame from the game logic and drives it through a double-buffered display memory. Each row is scanned with anti-ghosting blanking and BITS-bit PWM brightness. It sits between the game/render logic and the matrix pins.

## Interface
Parameters:
- ROWS, 8, number of matrix rows (>= 2)
- COLS, 8, number of matrix columns (>= 1)
- BITS, 2, intensity bits per pixel per colour (1..4)
- DWELL, 64, clocks per PWM slot (>= 1)
- BLANK, 4, clocks of all-off blanking before each row (>= 1)

Ports:
- clock  in  1  single system clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- red_level  in  [ROWS-1:0][COLS-1:0][BITS-1:0]  red intensity, pixel [r][c]; 0 = off, 2^BITS-1 = full
- green_level  in  same as red_level  green intensity
- load_req  in  1  request to copy red_level/green_level into the display buffer at the next frame boundary
- load_ack  out  1  one-cycle pulse: display buffer updated this cycle
- frame_start  out  1  one-cycle pulse on the first cycle of each frame
- red_driver  out  COLS  red column drive, active-high, bit c = column c
- green_driver  out  COLS  green column drive, active-high
- row_sink  out  ROWS  row select, active-low, one-cold; bit r = row r

## Operation
- Schedule counters: row (0..ROWS-1), phase (BLANK/ACTIVE), slot (0..2^BITS-2), dwell (0..DWELL-1), blank count (0..BLANK-1).
- Per row: BLANK state for BLANK cycles, then ACTIVE for NSLOT = 2^BITS-1 slots of DWELL cycles each.
  - Row period P = BLANK + NSLOT*DWELL.
  - Frame period F = ROWS*P.
- BLANK state:
  - row_sink = all 1s.
  - red_driver and green_driver = 0.
- ACTIVE state, row r, slot s:
  - row_sink = ~(1 << r).
  - red_driver[c] = (disp_red[r][c] > s).
  - green_driver[c] = (disp_green[r][c] > s).
  - Result: level L is lit for L*DWELL of the NSLOT*DWELL active cycles. Level 0 is never lit. Maximum level is lit for all active cycles.
- State transitions:
  - BLANK -> ACTIVE after the last blank cycle.
  - Within ACTIVE, dwell wraps and advances slot.
  - After the last cycle of slot NSLOT-1, go to BLANK of row+1. Row ROWS-1 wraps to row 0, which is a frame boundary.
- Double buffer: pending flag is set by any cycle with load_req = 1. A second request before service is merged into the same pending flag.
- Frame boundary swap: on the first BLANK cycle of row 0, if pending or load_req = 1 that cycle:
  - disp_red/disp_green take the current red_level/green_level.
  - load_ack pulses.
  - pending clears.
- The display buffer never changes mid-frame. Inputs may change freely between swaps.
- Reset:
  - Counters go to row 0, BLANK, all counts 0.
  - Display buffer cleared to all 0.
  - pending = 0.

## Timing
- All outputs are registered.
- Output reset values while reset = 1: row_sink = all 1s, red_driver = 0, green_driver = 0, frame_start = 0, load_ack = 0.
- Cycle numbering: cycle k is the k-th clock edge after reset deasserts. Outputs at cycle k reflect schedule position k mod F.
- Cycle 0 is the first BLANK cycle of row 0, so frame_start = 1 at cycle 0. frame_start repeats every F cycles.
- Row r is active at cycles r*P+BLANK .. (r+1)*P-1 within the frame.
- load_ack coincides with frame_start. The new data appears on drivers at the first ACTIVE cycle of row 0, i.e. BLANK cycles later.
- Request latency: load_req at frame position q is acknowledged F-q cycles later, or in the same cycle if q = 0.
- Reset asserted mid-operation:
  - Outputs take reset values on the next edge.
  - In-flight pending request is discarded.
  - Schedule restarts at cycle 0 after release.
- Row overlap: no cycle may have two rows sinking, and no cycle may drive columns during BLANK.

## Test plan
Bench parameters: ROWS=8, COLS=8, BITS=2, DWELL=4, BLANK=2, giving P=14 and F=112.

- Reset: hold reset 3 cycles with load_req=0 -> row_sink=8'hFF, drivers 0, load_ack=0 throughout. After release:
  - frame_start=1 at cycle 0.
  - row_sink=8'hFE at cycles 2..13 with drivers 0 (buffer cleared).
  - row_sink=8'hFF at cycles 14..15.
- Deferred load: all red levels 3, green 0, pulse load_req at cycle 30 -> no driver change before cycle 112. Then:
  - load_ack=1 and frame_start=1 at cycle 112.
  - red_driver=8'hFF on every ACTIVE cycle of every row in the next frame.
  - green_driver=0.
- PWM: row 0 red levels c0=0, c1=1, c2=2, c3=3, others 0; loaded -> during row 0:
  - red_driver=8'b00001110 for slot 0 (4 cycles).
  - red_driver=8'b00001100 for slot 1.
  - red_driver=8'b00001000 for slot 2.
- Scan order: row_sink cycles 8'hFE, FD, FB, F7, EF, DF, BF, 7F, each active 12 cycles and separated by 2 cycles of 8'hFF. Then wraps to 8'hFE with frame_start every 112 cycles.
- Handshake edges:
  - load_req high exactly on a frame_start cycle -> load_ack the same cycle.
  - Two load_req pulses within one frame -> exactly one load_ack, carrying the inputs present at the boundary.
- Mid-frame reset: loaded frame displaying, assert reset at cycle 50 for 1 cycle ->
  - Next edge: row_sink=8'hFF, drivers 0.
  - Restart at row 0 with drivers 0 (buffer cleared) until a new load.

Source files
------------

// File: rtl/led_matrix_scan_pwm_if.sv
// Frame payload and load handshake between the render logic and the matrix scanner.
interface led_matrix_scan_pwm_if #(
  parameter int unsigned ROWS = 8,
  parameter int unsigned COLS = 8,
  parameter int unsigned BITS = 2
);
  logic [ROWS-1:0][COLS-1:0][BITS-1:0] red_level;
  logic [ROWS-1:0][COLS-1:0][BITS-1:0] green_level;
  logic                                load_req;
  logic                                load_ack;

  modport master (output red_level, output green_level, output load_req, input load_ack);
  modport slave  (input red_level, input green_level, input load_req, output load_ack);
endinterface

// File: rtl/led_matrix_scan_pwm.sv
// Bicolour LED matrix row scanner: double-buffered frame, per-row blanking and
// BITS-bit PWM brightness built from 2^BITS-1 equal dwell slots.
module led_matrix_scan_pwm #(
  parameter int unsigned ROWS  = 8,
  parameter int unsigned COLS  = 8,
  parameter int unsigned BITS  = 2,
  parameter int unsigned DWELL = 64,
  parameter int unsigned BLANK = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  led_matrix_scan_pwm_if.slave  bus,
  output logic                  frame_start,
  output logic [COLS-1:0]       red_driver,
  output logic [COLS-1:0]       green_driver,
  output logic [ROWS-1:0]       row_sink
);

  localparam int unsigned NSLOT   = (1 << BITS) - 1;
  localparam int unsigned ROW_W   = (ROWS > 1)  ? $clog2(ROWS)  : 1;
  localparam int unsigned SLOT_W  = BITS;
  localparam int unsigned DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int unsigned BLANK_W = (BLANK > 1) ? $clog2(BLANK) : 1;

  typedef logic [ROWS-1:0][COLS-1:0][BITS-1:0] frame_t;
  typedef enum logic {PH_BLANK, PH_ACTIVE} phase_e;

  phase_e             phase_q, phase_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [BLANK_W-1:0] blank_q, blank_d;
  frame_t             disp_red_q, disp_red_d;
  frame_t             disp_green_q, disp_green_d;
  logic               pending_q, pending_d;
  logic               load_ack_q, load_ack_d;
  logic               frame_start_q, frame_start_d;
  logic [COLS-1:0]    red_q, red_d;
  logic [COLS-1:0]    green_q, green_d;
  logic [ROWS-1:0]    sink_q, sink_d;
  logic               boundary_c;

  // Schedule counters point at the position the next output register load will show.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q       <= PH_BLANK;
      row_q         <= '0;
      slot_q        <= '0;
      dwell_q       <= '0;
      blank_q       <= '0;
      disp_red_q    <= '0;
      disp_green_q  <= '0;
      pending_q     <= 1'b0;
      load_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
      red_q         <= '0;
      green_q       <= '0;
      sink_q        <= '1;
    end else begin
      phase_q       <= phase_d;
      row_q         <= row_d;
      slot_q        <= slot_d;
      dwell_q       <= dwell_d;
      blank_q       <= blank_d;
      disp_red_q    <= disp_red_d;
      disp_green_q  <= disp_green_d;
      pending_q     <= pending_d;
      load_ack_q    <= load_ack_d;
      frame_start_q <= frame_start_d;
      red_q         <= red_d;
      green_q       <= green_d;
      sink_q        <= sink_d;
    end
  end

  always_comb begin
    phase_d       = phase_q;
    row_d         = row_q;
    slot_d        = slot_q;
    dwell_d       = dwell_q;
    blank_d       = blank_q;
    disp_red_d    = disp_red_q;
    disp_green_d  = disp_green_q;
    pending_d     = pending_q | bus.load_req;
    load_ack_d    = 1'b0;
    frame_start_d = 1'b0;
    red_d         = '0;
    green_d       = '0;
    sink_d        = '1;

    boundary_c = (phase_q == PH_BLANK) && (row_q == '0) && (blank_q == '0);

    // Buffer swap only at the frame boundary so a frame is never torn.
    if (boundary_c) begin
      frame_start_d = 1'b1;
      pending_d     = 1'b0;
      if (pending_q || bus.load_req) begin
        disp_red_d   = bus.red_level;
        disp_green_d = bus.green_level;
        load_ack_d   = 1'b1;
      end
    end

    case (phase_q)
      PH_BLANK: begin
        if (blank_q == BLANK_W'(BLANK - 1)) begin
          blank_d = '0;
          phase_d = PH_ACTIVE;
        end else begin
          blank_d = blank_q + BLANK_W'(1);
        end
      end
      PH_ACTIVE: begin
        sink_d = ~(ROWS'(1) << row_q);
        for (int c = 0; c < int'(COLS); c++) begin
          red_d[c]   = disp_red_q[row_q][c] > slot_q;
          green_d[c] = disp_green_q[row_q][c] > slot_q;
        end
        if (dwell_q == DWELL_W'(DWELL - 1)) begin
          dwell_d = '0;
          if (slot_q == SLOT_W'(NSLOT - 1)) begin
            slot_d  = '0;
            phase_d = PH_BLANK;
            row_d   = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end else begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end
      default: phase_d = PH_BLANK;
    endcase
  end

  assign bus.load_ack  = load_ack_q;
  assign frame_start   = frame_start_q;
  assign red_driver    = red_q;
  assign green_driver  = green_q;
  assign row_sink      = sink_q;

endmodule

// File: tb/tb_led_matrix_scan_pwm.sv
// Directed bench for led_matrix_scan_pwm with a position-based reference of the scan.
module tb_led_matrix_scan_pwm;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int BITS  = 2;
  localparam int DWELL = 4;
  localparam int BLANK = 2;
  localparam int P     = BLANK + ((1 << BITS) - 1) * DWELL;
  localparam int F     = ROWS * P;

  logic            clock;
  logic            reset;
  logic            frame_start;
  logic [COLS-1:0] red_driver;
  logic [COLS-1:0] green_driver;
  logic [ROWS-1:0] row_sink;

  led_matrix_scan_pwm_if #(.ROWS(ROWS), .COLS(COLS), .BITS(BITS)) bus ();

  led_matrix_scan_pwm #(
    .ROWS(ROWS), .COLS(COLS), .BITS(BITS), .DWELL(DWELL), .BLANK(BLANK)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .frame_start  (frame_start),
    .red_driver   (red_driver),
    .green_driver (green_driver),
    .row_sink     (row_sink)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = -1;
  int ack_cnt  = 0;
  int a0;
  int a1;
  logic [1:0] m_red   [ROWS][COLS];
  logic [1:0] m_green [ROWS][COLS];
  logic       m_pend;
  logic [7:0] scan_tab [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_sink(input int pos);
    int row;
    int off;
    logic [7:0] one;
    row = pos / P;
    off = pos % P;
    one = 8'd1;
    if (off < BLANK) return 8'hFF;
    return ~(one << row);
  endfunction

  function automatic logic [7:0] exp_cols(input int pos, input bit grn);
    int row;
    int off;
    int slot;
    logic [7:0] res;
    res  = '0;
    row  = pos / P;
    off  = pos % P;
    if (off < BLANK) return res;
    slot = (off - BLANK) / DWELL;
    for (int c = 0; c < COLS; c++)
      res[c] = grn ? (int'(m_green[row][c]) > slot) : (int'(m_red[row][c]) > slot);
    return res;
  endfunction

  task automatic set_all(input bit grn, input logic [1:0] v);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (grn) bus.green_level[r][c] = v;
        else     bus.red_level[r][c]   = v;
  endtask

  // One clock: advance the reference, then compare every output.
  task automatic tick();
    int   pos;
    logic exp_ack;
    logic was_rst;
    exp_ack = 1'b0;
    was_rst = reset;
    if (was_rst) begin
      m_pend = 1'b0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          m_red[r][c]   = 2'd0;
          m_green[r][c] = 2'd0;
        end
    end else begin
      pos = (cyc + 1) % F;
      if (pos == 0) begin
        if (m_pend || bus.load_req) begin
          exp_ack = 1'b1;
          for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
              m_red[r][c]   = bus.red_level[r][c];
              m_green[r][c] = bus.green_level[r][c];
            end
        end
        m_pend = 1'b0;
      end else begin
        m_pend = m_pend | bus.load_req;
      end
    end
    @(posedge clock);
    #1;
    if (was_rst) begin
      cyc = -1;
      check("rst_sink",  32'(row_sink),     32'hFF);
      check("rst_red",   32'(red_driver),   32'h0);
      check("rst_green", 32'(green_driver), 32'h0);
      check("rst_fs",    32'(frame_start),  32'h0);
      check("rst_ack",   32'(bus.load_ack), 32'h0);
    end else begin
      cyc++;
      pos = cyc % F;
      check("sink",  32'(row_sink),     32'(exp_sink(pos)));
      check("red",   32'(red_driver),   32'(exp_cols(pos, 1'b0)));
      check("green", 32'(green_driver), 32'(exp_cols(pos, 1'b1)));
      check("fs",    32'(frame_start),  32'(pos == 0));
      check("ack",   32'(bus.load_ack), 32'(exp_ack));
      if (bus.load_ack) ack_cnt++;
    end
  endtask

  task automatic run_until(input int k);
    while (cyc < k) tick();
  endtask

  initial begin
    scan_tab[0] = 8'hFE; scan_tab[1] = 8'hFD; scan_tab[2] = 8'hFB; scan_tab[3] = 8'hF7;
    scan_tab[4] = 8'hEF; scan_tab[5] = 8'hDF; scan_tab[6] = 8'hBF; scan_tab[7] = 8'h7F;
    reset        = 1'b1;
    bus.load_req = 1'b0;
    set_all(1'b0, 2'd0);
    set_all(1'b1, 2'd0);
    repeat (3) tick();
    reset = 1'b0;

    // Cleared buffer after reset.
    run_until(0);  check("fs_c0", 32'(frame_start), 32'h1);
    run_until(2);  check("sink_c2", 32'(row_sink), 32'hFE); check("red_c2", 32'(red_driver), 32'h0);
    run_until(13); check("sink_c13", 32'(row_sink), 32'hFE);
    run_until(14); check("sink_c14", 32'(row_sink), 32'hFF);
    run_until(15); check("sink_c15", 32'(row_sink), 32'hFF);

    // Deferred load: request mid-frame, serviced at the next boundary.
    set_all(1'b0, 2'd3);
    run_until(29); bus.load_req = 1'b1; tick(); bus.load_req = 1'b0;
    run_until(111); check("no_early_ack", 32'(ack_cnt), 32'h0);
    check("red_pre_swap", 32'(red_driver), 32'h0);
    run_until(112); check("ack_c112", 32'(bus.load_ack), 32'h1); check("fs_c112", 32'(frame_start), 32'h1);
    run_until(114); check("red_full", 32'(red_driver), 32'hFF); check("green_off", 32'(green_driver), 32'h0);
    set_all(1'b0, 2'd0);
    run_until(223); check("red_hold_midframe", 32'(red_driver), 32'hFF);

    // PWM pattern loaded with a request exactly on the boundary cycle.
    bus.red_level[0][0] = 2'd0;
    bus.red_level[0][1] = 2'd1;
    bus.red_level[0][2] = 2'd2;
    bus.red_level[0][3] = 2'd3;
    bus.load_req = 1'b1; tick(); bus.load_req = 1'b0;
    check("ack_same_cycle", 32'(bus.load_ack), 32'h1);
    run_until(226); check("pwm_s0a", 32'(red_driver), 32'h0E);
    run_until(229); check("pwm_s0b", 32'(red_driver), 32'h0E);
    run_until(230); check("pwm_s1a", 32'(red_driver), 32'h0C);
    run_until(233); check("pwm_s1b", 32'(red_driver), 32'h0C);
    run_until(234); check("pwm_s2a", 32'(red_driver), 32'h08);
    run_until(237); check("pwm_s2b", 32'(red_driver), 32'h08);

    // Row scan order and blanking gaps.
    for (int r = 0; r < ROWS; r++) begin
      run_until(224 + r * P + BLANK);  check("scan_first", 32'(row_sink), 32'(scan_tab[r]));
      run_until(224 + r * P + P - 1);  check("scan_last",  32'(row_sink), 32'(scan_tab[r]));
      run_until(224 + r * P + P);      check("scan_gap",   32'(row_sink), 32'hFF);
    end
    check("fs_wrap", 32'(frame_start), 32'h1);

    // Two requests in one frame merge into a single ack with boundary-time data.
    run_until(355); set_all(1'b1, 2'd1); bus.load_req = 1'b1; tick(); bus.load_req = 1'b0;
    run_until(395); set_all(1'b1, 2'd2); bus.load_req = 1'b1; tick(); bus.load_req = 1'b0;
    run_until(435); set_all(1'b1, 2'd3);
    a0 = ack_cnt;
    run_until(448); check("merged_ack", 32'(bus.load_ack), 32'h1);
    check("one_ack", 32'(ack_cnt - a0), 32'h1);
    run_until(450); check("green_new_s0", 32'(green_driver), 32'hFF); check("red_keep", 32'(red_driver), 32'h0E);
    run_until(458); check("green_new_s2", 32'(green_driver), 32'hFF);

    // Mid-frame reset discards a pending request and clears the buffer.
    run_until(487); set_all(1'b0, 2'd2); bus.load_req = 1'b1; tick(); bus.load_req = 1'b0;
    run_until(497); reset = 1'b1; tick(); reset = 1'b0;
    check("mrst_sink", 32'(row_sink), 32'hFF);
    check("mrst_red",  32'(red_driver), 32'h0);
    a1 = ack_cnt;
    run_until(0);  check("mrst_fs", 32'(frame_start), 32'h1);
    run_until(2);  check("mrst_sink_c2", 32'(row_sink), 32'hFE);
    check("mrst_red_c2", 32'(red_driver), 32'h0); check("mrst_green_c2", 32'(green_driver), 32'h0);
    run_until(112); check("mrst_no_ack", 32'(ack_cnt - a1), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
